// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
//
// Purpose:
//    Watches a core's architectural commits (register-file writes and data
//    memory writes), turns each one into a trace record stamped with a 16-bit
//    cycle count, and queues the records in a first-word-fall-through FIFO
//    for a downstream consumer with a valid/ready handshake.
//    Once the core halts, capture stops, the FIFO drains, and done rises
//    when it is empty.
//
// Ports:
//    clk            in   single clock, rising edge
//    reset          in   synchronous, active-high reset
//    reg_write_sig  in   register-file write this cycle
//    reg_num        in   destination register (x0 writes are discarded)
//    reg_data       in   value written to reg_num
//    wr             in   data-memory write this cycle
//    addr           in   data-memory address
//    wr_data        in   data-memory write data
//    Halted         in   core has halted (level)
//    trace_ready    in   consumer accepts the head record
//    trace_valid    out  head record present
//    trace_kind     out  0 = register write, 1 = memory write
//    trace_idx      out  register number (zero-extended) or memory address
//    trace_data     out  written value
//    trace_cycle    out  cycle stamp of the capture
//    overflow       out  sticky, set when any record is dropped
//    drop_count     out  saturating count of dropped records
//    done           out  halted and fully drained

module commit_trace_buffer #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              reg_write_sig,
   input  logic [4:0]        reg_num,
   input  logic [31:0]       reg_data,
   input  logic              wr,
   input  logic [8:0]        addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              Halted,
   input  logic              trace_ready,
   output logic              trace_valid,
   output logic              trace_kind,
   output logic [8:0]        trace_idx,
   output logic [DATA_W-1:0] trace_data,
   output logic [15:0]       trace_cycle,
   output logic              overflow,
   output logic [7:0]        drop_count,
   output logic              done
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int REC_W = 1 + 9 + DATA_W + 16;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [15:0]        cycleCnt_q, cycleCnt_d;
   logic [7:0]         dropCnt_q, dropCnt_d;
   logic               overflow_q, overflow_d;
   logic [REC_W-1:0]   store_q [DEPTH];

   logic               capture;
   logic               regRec;
   logic               memRec;
   logic               fifoEmpty;
   logic               pop;
   logic [CNT_W-1:0]   freeCap;
   logic               pushReg;
   logic               pushMem;
   logic               dropReg;
   logic               dropMem;
   logic [PTR_W-1:0]   memSlot;
   logic [REC_W-1:0]   regEntry;
   logic [REC_W-1:0]   memEntry;
   logic [REC_W-1:0]   headEntry;
   logic [8:0]         dropSum;

   // Capture decisions. Room for this cycle's records includes the slot
   // freed by a simultaneous pop. When only one slot is free and both kinds
   // of record arrive, the register record wins because it is ordered first.
   always_comb begin
      capture   = (state_q == RUN);
      regRec    = capture && reg_write_sig && (reg_num != 5'd0);
      memRec    = capture && wr;
      fifoEmpty = (count_q == '0);
      pop       = !fifoEmpty && trace_ready;
      freeCap   = CNT_W'(DEPTH) - count_q + CNT_W'(pop);
      pushReg   = regRec && (freeCap != '0);
      pushMem   = memRec && (regRec ? (freeCap >= CNT_W'(2)) : (freeCap != '0));
      dropReg   = regRec && !pushReg;
      dropMem   = memRec && !pushMem;
      memSlot   = wrPtr_q + PTR_W'(pushReg);
      regEntry  = {1'b0, {4'b0000, reg_num}, DATA_W'(reg_data), cycleCnt_q};
      memEntry  = {1'b1, addr, wr_data, cycleCnt_q};
   end

   // Next-state logic: FSM transitions, pointer/occupancy bookkeeping,
   // cycle stamp counter (frozen once out of RUN) and the saturating drop
   // counter. The drop sum is one bit wider so saturation is a simple carry test.
   always_comb begin
      state_d    = state_q;
      wrPtr_d    = wrPtr_q + PTR_W'(pushReg) + PTR_W'(pushMem);
      rdPtr_d    = rdPtr_q + PTR_W'(pop);
      count_d    = count_q + CNT_W'(pushReg) + CNT_W'(pushMem) - CNT_W'(pop);
      cycleCnt_d = capture ? (cycleCnt_q + 16'd1) : cycleCnt_q;
      dropSum    = {1'b0, dropCnt_q} + 9'(dropReg) + 9'(dropMem);
      dropCnt_d  = dropSum[8] ? 8'hFF : dropSum[7:0];
      overflow_d = overflow_q | dropReg | dropMem;

      case (state_q)
         RUN:     if (Halted) state_d = DRAIN;
         DRAIN:   if (fifoEmpty) state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = RUN;
      endcase
   end

   // Control state register. Reset wins over any push or pop in the same
   // cycle and empties the FIFO by clearing the pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RUN;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         cycleCnt_q <= '0;
         dropCnt_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         count_q    <= count_d;
         cycleCnt_q <= cycleCnt_d;
         dropCnt_q  <= dropCnt_d;
         overflow_q <= overflow_d;
      end
   end

   // Record storage. It is not cleared on reset: an empty FIFO masks the
   // outputs, so stale contents are never visible. The memory record goes
   // into the slot after the register record when both are pushed together.
   always_ff @(posedge clk) begin
      if (!reset && pushReg) store_q[wrPtr_q] <= regEntry;
      if (!reset && pushMem) store_q[memSlot] <= memEntry;
   end

   // Output view of the head record, forced to zero while the FIFO is empty
   // so the trace fields read as 0 after reset and carry no stale data.
   always_comb begin
      headEntry   = store_q[rdPtr_q];
      trace_valid = !fifoEmpty;
      {trace_kind, trace_idx, trace_data, trace_cycle} = trace_valid ? headEntry : '0;
      overflow    = overflow_q;
      drop_count  = dropCnt_q;
      done        = (state_q == DONE) || ((state_q == DRAIN) && fifoEmpty);
   end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer
//
// Purpose:
//    Directed self-checking bench for commit_trace_buffer with hand-computed
//    expectations: reset state, single and dual captures, x0 filtering,
//    overflow and drop counting, halt/drain/done, stamp wrap, and reset
//    during drain.
//
// Ports: none (top-level bench).

module tb_commit_trace_buffer;

   logic        clk;
   logic        reset;
   logic        reg_write_sig;
   logic [4:0]  reg_num;
   logic [31:0] reg_data;
   logic        wr;
   logic [8:0]  addr;
   logic [31:0] wr_data;
   logic        Halted;
   logic        trace_ready;
   logic        trace_valid;
   logic        trace_kind;
   logic [8:0]  trace_idx;
   logic [31:0] trace_data;
   logic [15:0] trace_cycle;
   logic        overflow;
   logic [7:0]  drop_count;
   logic        done;

   int          checkCount;
   int          passCount;
   int          tbCycle;
   logic [15:0] lastStamp;
   logic [15:0] holdStamp;

   commit_trace_buffer #(
      .DATA_W (32),
      .DEPTH  (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .reg_write_sig (reg_write_sig),
      .reg_num       (reg_num),
      .reg_data      (reg_data),
      .wr            (wr),
      .addr          (addr),
      .wr_data       (wr_data),
      .Halted        (Halted),
      .trace_ready   (trace_ready),
      .trace_valid   (trace_valid),
      .trace_kind    (trace_kind),
      .trace_idx     (trace_idx),
      .trace_data    (trace_data),
      .trace_cycle   (trace_cycle),
      .overflow      (overflow),
      .drop_count    (drop_count),
      .done          (done)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against its expected value and count it.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
   endtask

   // Advance one cycle; inputs change and outputs are sampled 1 unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      tbCycle++;
   endtask

   // Drive one cycle of commit activity, remembering its expected stamp.
   task automatic applyStimulus(input logic rw, input logic [4:0] rn,
                                input logic [31:0] rd, input logic w,
                                input logic [8:0] a, input logic [31:0] wd);
      reg_write_sig = rw;
      reg_num       = rn;
      reg_data      = rd;
      wr            = w;
      addr          = a;
      wr_data       = wd;
      lastStamp     = 16'(tbCycle);
      tick();
      reg_write_sig = 1'b0;
      wr            = 1'b0;
   endtask

   // Accept the current head record.
   task automatic popOne();
      trace_ready = 1'b1;
      tick();
      trace_ready = 1'b0;
   endtask

   // Hold reset for two edges; cycle 0 is the first cycle after release.
   task automatic resetDut();
      reset         = 1'b1;
      reg_write_sig = 1'b0;
      wr            = 1'b0;
      Halted        = 1'b0;
      trace_ready   = 1'b0;
      tick();
      tick();
      reset   = 1'b0;
      tbCycle = 0;
   endtask

   // Compare the whole head record.
   task automatic checkHead(input string tag, input logic kind, input logic [8:0] idx,
                            input logic [31:0] data, input logic [15:0] stamp);
      checkOutput({tag, ".valid"}, trace_valid, 1'b1);
      checkOutput({tag, ".kind"},  trace_kind,  kind);
      checkOutput({tag, ".idx"},   trace_idx,   idx);
      checkOutput({tag, ".data"},  trace_data,  data);
      checkOutput({tag, ".cycle"}, trace_cycle, stamp);
   endtask

   initial begin
      checkCount    = 0;
      passCount     = 0;
      tbCycle       = 0;
      reset         = 1'b1;
      reg_write_sig = 1'b0;
      reg_num       = '0;
      reg_data      = '0;
      wr            = 1'b0;
      addr          = '0;
      wr_data       = '0;
      Halted        = 1'b0;
      trace_ready   = 1'b0;

      // Reset state
      resetDut();
      checkOutput("rst.valid",    trace_valid, 1'b0);
      checkOutput("rst.kind",     trace_kind,  1'b0);
      checkOutput("rst.idx",      trace_idx,   9'd0);
      checkOutput("rst.data",     trace_data,  32'd0);
      checkOutput("rst.cycle",    trace_cycle, 16'd0);
      checkOutput("rst.overflow", overflow,    1'b0);
      checkOutput("rst.drops",    drop_count,  8'd0);
      checkOutput("rst.done",     done,        1'b0);

      // Single register write in cycle 3, held with trace_ready low
      tick(); tick(); tick();
      applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 9'd0, 32'd0);
      checkHead("single", 1'b0, 9'd5, 32'hDEADBEEF, 16'd3);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("hold.valid", trace_valid, 1'b1);
         checkOutput("hold.data",  trace_data,  32'hDEADBEEF);
         checkOutput("hold.cycle", trace_cycle, 16'd3);
      end
      popOne();
      checkOutput("single.empty", trace_valid, 1'b0);

      // Dual write: register record first, memory record second, same stamp
      applyStimulus(1'b1, 5'd7, 32'h11, 1'b1, 9'h1FF, 32'h22);
      holdStamp = lastStamp;
      checkHead("dual0", 1'b0, 9'd7, 32'h11, holdStamp);
      popOne();
      checkHead("dual1", 1'b1, 9'h1FF, 32'h22, holdStamp);
      popOne();
      checkOutput("dual.empty", trace_valid, 1'b0);

      // Write to x0 produces no record and is not a drop
      applyStimulus(1'b1, 5'd0, 32'hCAFE, 1'b0, 9'd0, 32'd0);
      checkOutput("x0.valid", trace_valid, 1'b0);
      checkOutput("x0.drops", drop_count,  8'd0);

      // Overflow: 20 memory writes into a 16-entry FIFO with no consumer
      resetDut();
      for (int i = 0; i < 20; i++)
         applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 9'(i), 32'h100 + 32'(i));
      checkOutput("ovf.flag",  overflow,   1'b1);
      checkOutput("ovf.drops", drop_count, 8'd4);
      checkHead("ovf.head", 1'b1, 9'd0, 32'h100, 16'd0);

      // Full FIFO with a pop: register record fits, memory record dropped
      trace_ready = 1'b1;
      applyStimulus(1'b1, 5'd9, 32'h55, 1'b1, 9'h0AA, 32'h66);
      trace_ready = 1'b0;
      holdStamp = lastStamp;
      checkOutput("ovf2.drops", drop_count, 8'd5);
      for (int i = 0; i < 15; i++) begin
         checkOutput("ovf.order", trace_data, 32'h101 + 32'(i));
         popOne();
      end
      checkHead("ovf.last", 1'b0, 9'd9, 32'h55, holdStamp);
      popOne();
      checkOutput("ovf.empty", trace_valid, 1'b0);

      // Halt drain: three records, then Halted with the consumer ready
      resetDut();
      applyStimulus(1'b1, 5'd1, 32'hA1, 1'b0, 9'd0, 32'd0);
      applyStimulus(1'b1, 5'd2, 32'hA2, 1'b0, 9'd0, 32'd0);
      applyStimulus(1'b1, 5'd3, 32'hA3, 1'b0, 9'd0, 32'd0);
      Halted      = 1'b1;
      trace_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checkOutput("drain.valid", trace_valid, 1'b1);
         checkOutput("drain.data",  trace_data,  32'hA1 + 32'(i));
         checkOutput("drain.done",  done,        1'b0);
         tick();
         wr      = 1'b1;
         addr    = 9'd3;
         wr_data = 32'h77;
      end
      checkOutput("drain.emptyValid", trace_valid, 1'b0);
      checkOutput("drain.doneNow",    done,        1'b1);
      tick(); tick();
      checkOutput("drain.ignoreWr", trace_valid, 1'b0);
      checkOutput("drain.doneHeld", done,        1'b1);
      wr          = 1'b0;
      trace_ready = 1'b0;

      // Halt with an empty FIFO: done one cycle later
      resetDut();
      Halted = 1'b1;
      checkOutput("emptyHalt.before", done, 1'b0);
      tick();
      checkOutput("emptyHalt.after", done, 1'b1);

      // Cycle stamp wraps after 65536 cycles
      resetDut();
      for (int i = 0; i < 65537; i++) tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 9'h012, 32'hBEEF);
      checkHead("wrap", 1'b1, 9'h012, 32'hBEEF, 16'h0001);

      // Reset while draining with a record visible
      Halted = 1'b1;
      tick();
      checkOutput("midRst.preValid", trace_valid, 1'b1);
      checkOutput("midRst.preDone",  done,        1'b0);
      reset = 1'b1;
      tick();
      checkOutput("midRst.valid", trace_valid, 1'b0);
      checkOutput("midRst.done",  done,        1'b0);
      checkOutput("midRst.data",  trace_data,  32'd0);
      reset   = 1'b0;
      Halted  = 1'b0;
      tbCycle = 0;
      applyStimulus(1'b1, 5'd4, 32'h44, 1'b0, 9'd0, 32'd0);
      checkHead("midRst.run", 1'b0, 9'd4, 32'h44, 16'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 Parameter DATA_W, default 32, width of data payloads.
REQ-002 Parameter DEPTH, default 16, FIFO entries; power of two, at least 4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 reg_write_sig  input  1  core register-file write this cycle.
REQ-006 reg_num  input  5  destination register of that write.
REQ-007 reg_data  input  32  value written to reg_num.
REQ-008 wr  input  1  core data-memory write this cycle.
REQ-009 addr  input  9  data-memory address.
REQ-010 wr_data  input  DATA_W  data-memory write data.
REQ-011 Halted  input  1  core has halted; level, stays high.
REQ-012 trace_ready  input  1  consumer accepts the head record.
REQ-013 trace_valid  output  1  head record present.
REQ-014 trace_kind  output  1  record type: 0 = register write, 1 = memory write.
REQ-015 trace_idx  output  9  register number zero-extended, or memory address.
REQ-016 trace_data  output  DATA_W  written value.
REQ-017 trace_cycle  output  16  cycle stamp of the capture.
REQ-018 overflow  output  1  sticky; set when any record is dropped.
REQ-019 drop_count  output  8  dropped-record count, saturating at 255.
REQ-020 done  output  1  high once the core has halted and all records are drained.

Function
REQ-021 The state machine SHALL have three states: RUN, DRAIN and DONE.
- RUN goes to DRAIN on the first cycle Halted=1.
- DRAIN goes to DONE on the cycle the FIFO becomes empty, including immediately when it is already empty.
- DONE is held until reset.
REQ-022 Capture SHALL happen only in RUN, including the cycle Halted is first seen high; inputs are ignored in DRAIN and DONE.
REQ-023 A register record SHALL be generated when reg_write_sig=1 and reg_num!=0; writes to x0 are discarded and not counted as drops.
REQ-024 A memory record SHALL be generated when wr=1.
REQ-025 When both records occur in one cycle, both SHALL be enqueued that cycle, register record first.
REQ-026 Free capacity SHALL be DEPTH minus occupancy, plus 1 if a pop occurs in the same cycle.
- If capacity is 1 and two records are pending, the register record is kept and the memory record is dropped.
- If capacity is 0, all pending records are dropped.
REQ-027 Each dropped record SHALL set overflow and increment drop_count, which saturates at 255.
REQ-028 The cycle counter SHALL be 16 bits and reset to 0.
- Increments every RUN cycle and wraps from 0xFFFF to 0x0000.
- Frozen in DRAIN and DONE.
- A record's stamp is the counter value in its capture cycle.
REQ-029 The FIFO SHALL be first-word fall-through with registered storage: a record captured in cycle N is visible at the outputs in cycle N+1 at the earliest.
REQ-030 trace_valid SHALL equal FIFO not-empty.
- A pop occurs on trace_valid && trace_ready.
- While trace_valid=1 and trace_ready=0, all trace_* outputs hold stable.
REQ-031 Pointers SHALL wrap modulo DEPTH; occupancy SHALL never exceed DEPTH or underflow.
REQ-032 trace_ready with an empty FIFO SHALL have no effect.

Reset
REQ-033 On reset=1 at a clock edge, the block SHALL enter the reset state.
- State = RUN, FIFO empty, pointers 0, cycle counter 0.
- trace_valid=0, overflow=0, drop_count=0, done=0.
- trace_kind, trace_idx, trace_data, trace_cycle = 0.
REQ-034 Reset asserted mid-operation in any state SHALL discard all buffered records, with no partial output, and take priority over push and pop in the same cycle.

Verification
REQ-035 Single write: reset, then reg_write_sig=1, reg_num=5, reg_data=0xDEADBEEF in cycle 3.
- Required response: from cycle 4, trace_valid=1, kind=0, idx=5, data=0xDEADBEEF, cycle=3.
- Hold trace_ready=0 for 5 cycles: outputs stay stable.
REQ-036 Dual write: reg write x7=0x11 and wr=1, addr=0x1FF, wr_data=0x22 in the same cycle.
- Required response: two records in order, (0,7,0x11) then (1,0x1FF,0x22), with identical stamps.
- Writes to x0 produce no record.
REQ-037 Overflow: trace_ready=0, 20 memory writes with DEPTH=16.
- Required response: 16 records retained, overflow=1, drop_count=4.
- Then one dual write with FIFO full and trace_ready=1: reg record kept, memory record dropped, drop_count=5.
REQ-038 Halt drain: 3 records queued, Halted=1, trace_ready=1.
- Required response: 3 records drained in order, done=1 on the cycle the FIFO empties.
- Writes after Halted are ignored.
- Halted with an empty FIFO gives done=1 one cycle later.
REQ-039 Wrap and reset: run 65537 cycles, then one write.
- Required response: stamp = 0x0001.
- Reset asserted while trace_valid=1 in DRAIN: next cycle trace_valid=0, done=0, counter=0, state RUN.
